// File: rtl/gearbox_pkg.sv
// Shared types and helpers for the byte-granular gearbox FIFO.
// Latency: none (package only).
// Backpressure: n/a.
// Contents: default byte width, a constant clog2, a modulo pointer add that
// works for any depth, and the pop-stride clamp rule.
package gearbox_pkg;

    localparam int BYTE_W_DEFAULT = 8;

    // Constant-foldable ceil(log2(v)); clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // (a + b) mod depth by a single compare-and-subtract.
    // Valid while a < depth and b <= depth, which every caller guarantees.
    function automatic int unsigned mod_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned depth);
        int unsigned s;
        s = a + b;
        if (s >= depth) begin
            s = s - depth;
        end
        return s;
    endfunction

    // A stride of zero or one that exceeds the window retires a whole window.
    function automatic int unsigned clamp_stride(input int unsigned s,
                                                 input int unsigned out_bytes);
        if ((s == 0) || (s > out_bytes)) begin
            return out_bytes;
        end
        return s;
    endfunction

endpackage

// File: rtl/byte_ring_store.sv
// Circular byte store with a rotated multi-lane write port and read window.
// Latency: write lands at the clock edge; the read window is combinational.
// Backpressure: none here; the caller only asserts wr_en when space exists.
// Ports: clk; wr_en/wr_ptr/wr_data (IN_BYTES lanes written at wr_ptr+i);
//        rd_ptr/rd_data (OUT_BYTES lanes read from rd_ptr+j). Storage is not reset.
module byte_ring_store
    import gearbox_pkg::*;
#(
    parameter int BYTE_W      = BYTE_W_DEFAULT,
    parameter int IN_BYTES    = 8,
    parameter int OUT_BYTES   = 3,
    parameter int DEPTH_BYTES = 12,
    parameter int PTR_W       = 4
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [PTR_W-1:0]              wr_ptr,
    input  logic [IN_BYTES*BYTE_W-1:0]    wr_data,
    input  logic [PTR_W-1:0]              rd_ptr,
    output logic [OUT_BYTES*BYTE_W-1:0]   rd_data
);

    logic [BYTE_W-1:0] mem_q [DEPTH_BYTES];
    logic [PTR_W-1:0]  wr_addr [IN_BYTES];
    logic [PTR_W-1:0]  rd_addr [OUT_BYTES];

    // Per-lane addresses; lane offsets never exceed the depth, so one
    // conditional subtract is enough for the wrap.
    always_comb begin
        for (int i = 0; i < IN_BYTES; i++) begin
            wr_addr[i] = PTR_W'(mod_add(32'(wr_ptr), i, DEPTH_BYTES));
        end
        for (int j = 0; j < OUT_BYTES; j++) begin
            rd_addr[j] = PTR_W'(mod_add(32'(rd_ptr), j, DEPTH_BYTES));
        end
    end

    // IN_BYTES <= DEPTH_BYTES, so the lane addresses are always distinct.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                mem_q[wr_addr[i]] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < OUT_BYTES; j++) begin
            rd_data[j*BYTE_W +: BYTE_W] = mem_q[rd_addr[j]];
        end
    end

endmodule

// File: rtl/gearbox_byte_fifo.sv
// Width-converting byte FIFO: IN_BYTES words in, OUT_BYTES windows out, per-pop stride.
// Latency: a word pushed at edge N is visible on out_data/out_valid after edge N.
// Backpressure: in_ready from registered count only (room for a full word); out_valid once a full window is held.
// Ports: clk, reset (async active-high); in_data/in_valid/in_ready; out_data/out_valid/out_ready;
//        stride (bytes retired per pop, 0 or >OUT_BYTES means OUT_BYTES); flush (sync clear); count.
module gearbox_byte_fifo
    import gearbox_pkg::*;
#(
    parameter int BYTE_W      = BYTE_W_DEFAULT,
    parameter int IN_BYTES    = 8,
    parameter int OUT_BYTES   = 3,
    parameter int DEPTH_BYTES = 12,
    parameter int CNT_W       = $clog2(DEPTH_BYTES + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [IN_BYTES*BYTE_W-1:0]        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [OUT_BYTES*BYTE_W-1:0]       out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic [$clog2(OUT_BYTES+1)-1:0]    stride,
    input  logic                              flush,
    output logic [CNT_W-1:0]                  count
);

    localparam int PTR_W = (DEPTH_BYTES > 1) ? clog2(DEPTH_BYTES) : 1;

    // Below this depth a partially filled store could hold fewer than
    // OUT_BYTES bytes yet lack room for a word, and both sides would stall.
    generate
        if (DEPTH_BYTES < IN_BYTES + OUT_BYTES - 1) begin : g_bad_depth
            $error("gearbox_byte_fifo: DEPTH_BYTES must be >= IN_BYTES + OUT_BYTES - 1");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] eff_stride;
    logic [CNT_W:0]   cnt_add;
    logic [CNT_W:0]   cnt_sub;

    assign in_ready  = (count_q <= CNT_W'(DEPTH_BYTES - IN_BYTES));
    assign out_valid = (count_q >= CNT_W'(OUT_BYTES));
    assign count     = count_q;

    always_comb begin
        push       = in_valid & in_ready;
        pop        = out_valid & out_ready;
        eff_stride = CNT_W'(clamp_stride(32'(stride), OUT_BYTES));

        cnt_add = push ? (CNT_W+1)'(IN_BYTES) : '0;
        cnt_sub = pop  ? {1'b0, eff_stride}   : '0;

        // The handshakes keep this inside 0..DEPTH_BYTES, so the extra
        // headroom bit is never needed in the stored value.
        count_d  = CNT_W'(({1'b0, count_q} + cnt_add) - cnt_sub);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            wr_ptr_d = PTR_W'(mod_add(32'(wr_ptr_q), IN_BYTES, DEPTH_BYTES));
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(mod_add(32'(rd_ptr_q), 32'(eff_stride), DEPTH_BYTES));
        end

        // Flush wins over any same-cycle push or pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A flushed push must not touch storage either, so the write is gated.
    byte_ring_store #(
        .BYTE_W      (BYTE_W),
        .IN_BYTES    (IN_BYTES),
        .OUT_BYTES   (OUT_BYTES),
        .DEPTH_BYTES (DEPTH_BYTES),
        .PTR_W       (PTR_W)
    ) u_store (
        .clk     (clk),
        .wr_en   (push & ~flush),
        .wr_ptr  (wr_ptr_q),
        .wr_data (in_data),
        .rd_ptr  (rd_ptr_q),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_gearbox_byte_fifo.sv
// Directed bench for gearbox_byte_fifo at IN=8, OUT=3, DEPTH=12.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each scenario task carries its own inline comparisons.
module tb_gearbox_byte_fifo;

    localparam int BYTE_W      = 8;
    localparam int IN_BYTES    = 8;
    localparam int OUT_BYTES   = 3;
    localparam int DEPTH_BYTES = 12;
    localparam int CNT_W       = $clog2(DEPTH_BYTES + 1);

    logic                          clk;
    logic                          reset;
    logic [IN_BYTES*BYTE_W-1:0]    in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [OUT_BYTES*BYTE_W-1:0]   out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [1:0]                    stride;
    logic                          flush;
    logic [CNT_W-1:0]              count;

    int n_cmp;
    int n_err;

    gearbox_byte_fifo #(
        .BYTE_W      (BYTE_W),
        .IN_BYTES    (IN_BYTES),
        .OUT_BYTES   (OUT_BYTES),
        .DEPTH_BYTES (DEPTH_BYTES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stride    (stride),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stride    = 2'd3;
        flush     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        tick();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_cmp++; if (count !== 4'd0)     begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        #2;
        reset = 1'b0;
    endtask

    task automatic test_push();
        apply_reset();
        push_word(64'h0706050403020100);
        n_cmp++; if (out_valid !== 1'b1)       begin n_err++; $display("FAIL push_out_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 24'h020100)  begin n_err++; $display("FAIL push_out_data got %h want 020100", out_data); end
        n_cmp++; if (count !== 4'd8)           begin n_err++; $display("FAIL push_count got %0d want 8", count); end
        n_cmp++; if (in_ready !== 1'b0)        begin n_err++; $display("FAIL push_in_ready got %b want 0", in_ready); end
        // A push offered while full must be ignored.
        push_word(64'hFFFFFFFFFFFFFFFF);
        n_cmp++; if (count !== 4'd8)           begin n_err++; $display("FAIL full_push_count got %0d want 8", count); end
        n_cmp++; if (out_data !== 24'h020100)  begin n_err++; $display("FAIL full_push_data got %h want 020100", out_data); end
    endtask

    task automatic test_pop_stride3();
        logic [23:0] exp_win [2];
        exp_win[0] = 24'h020100;
        exp_win[1] = 24'h050403;
        apply_reset();
        push_word(64'h0706050403020100);
        out_ready = 1'b1;
        stride    = 2'd3;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (out_data !== exp_win[k]) begin n_err++; $display("FAIL s3_window%0d got %h want %h", k, out_data, exp_win[k]); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 4'd2)     begin n_err++; $display("FAIL s3_count got %0d want 2", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL s3_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL s3_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_stride1();
        logic [23:0] exp;
        apply_reset();
        push_word(64'h0706050403020100);
        out_ready = 1'b1;
        stride    = 2'd1;
        for (int k = 0; k < 6; k++) begin
            exp = {8'(k + 2), 8'(k + 1), 8'(k)};
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL s1_valid%0d got %b want 1", k, out_valid); end
            n_cmp++; if (out_data !== exp)   begin n_err++; $display("FAIL s1_window%0d got %h want %h", k, out_data, exp); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL s1_end_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== 4'd2)     begin n_err++; $display("FAIL s1_end_count got %0d want 2", count); end

        // Stride 0 retires a full window.
        apply_reset();
        push_word(64'h0706050403020100);
        out_ready = 1'b1;
        stride    = 2'd0;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (count !== 4'd5)          begin n_err++; $display("FAIL s0_count got %0d want 5", count); end
        n_cmp++; if (out_data !== 24'h050403) begin n_err++; $display("FAIL s0_window got %h want 050403", out_data); end
    endtask

    task automatic test_wrap();
        logic [23:0] exp;
        apply_reset();
        push_word(64'h0706050403020100);
        out_ready = 1'b1;
        stride    = 2'd3;
        repeat (3) tick();   // third attempt is refused: only 2 bytes left
        out_ready = 1'b0;
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL wrap_pre_count got %0d want 2", count); end
        push_word(64'h0F0E0D0C0B0A0908);
        n_cmp++; if (count !== 4'd10) begin n_err++; $display("FAIL wrap_push_count got %0d want 10", count); end
        out_ready = 1'b1;
        stride    = 2'd1;
        for (int v = 6; v < 14; v++) begin
            exp = {8'(v + 2), 8'(v + 1), 8'(v)};
            n_cmp++; if (out_data !== exp) begin n_err++; $display("FAIL wrap_window%0d got %h want %h", v, out_data, exp); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_end_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== 4'd2)     begin n_err++; $display("FAIL wrap_end_count got %0d want 2", count); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_win [2];
        exp_win[0] = 24'h0B0A09;
        exp_win[1] = 24'h0E0D0C;
        apply_reset();
        push_word(64'h0706050403020100);
        out_ready = 1'b1;
        stride    = 2'd2;
        repeat (2) tick();
        out_ready = 1'b0;
        n_cmp++; if (count !== 4'd4)          begin n_err++; $display("FAIL simul_pre_count got %0d want 4", count); end
        n_cmp++; if (in_ready !== 1'b1)       begin n_err++; $display("FAIL simul_pre_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 24'h060504) begin n_err++; $display("FAIL simul_pre_window got %h want 060504", out_data); end
        // Push and pop on the same edge.
        in_valid  = 1'b1;
        in_data   = 64'h0F0E0D0C0B0A0908;
        out_ready = 1'b1;
        stride    = 2'd2;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (count !== 4'd10)         begin n_err++; $display("FAIL simul_count got %0d want 10", count); end
        n_cmp++; if (out_data !== 24'h080706) begin n_err++; $display("FAIL simul_window got %h want 080706", out_data); end
        // Full-window pops carry the read pointer across the 11 -> 0 boundary.
        out_ready = 1'b1;
        stride    = 2'd3;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (out_data !== exp_win[k]) begin n_err++; $display("FAIL b2b_window%0d got %h want %h", k, out_data, exp_win[k]); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL b2b_count got %0d want 1", count); end
    endtask

    task automatic test_flush();
        apply_reset();
        push_word(64'h0706050403020100);
        out_ready = 1'b1;
        stride    = 2'd3;
        tick();               // rd_ptr now 3, count 5
        in_valid  = 1'b1;
        in_data   = 64'hA7A6A5A4A3A2A1A0;
        flush     = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        n_cmp++; if (count !== 4'd0)     begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL flush_ready got %b want 1", in_ready); end
        // Flush with an acceptable push at count 0: word is dropped.
        in_valid = 1'b1;
        in_data  = 64'hB7B6B5B4B3B2B1B0;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_push_count got %0d want 0", count); end
        // Pointers restart at 0 after flush.
        push_word(64'h1716151413121110);
        n_cmp++; if (count !== 4'd8)          begin n_err++; $display("FAIL post_flush_count got %0d want 8", count); end
        n_cmp++; if (out_data !== 24'h121110) begin n_err++; $display("FAIL post_flush_window got %h want 121110", out_data); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_word(64'h0706050403020100);
        #2;
        reset = 1'b1;
        #1;                   // mid-cycle, no clock edge since reset rose
        n_cmp++; if (count !== 4'd0)     begin n_err++; $display("FAIL areset_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL areset_ready got %b want 1", in_ready); end
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_push();
        test_pop_stride3();
        test_stride1();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gearbox_byte_fifo.md
# gearbox_byte_fifo

Parametrised byte-granular width-converting FIFO.
- Accepts IN_BYTES-wide words and delivers OUT_BYTES-wide windows over a circular byte store of arbitrary (non-power-of-two) depth.
- The consumer chooses per pop how many bytes to retire, which supports overlapping (stride < OUT_BYTES) reads for sliding-window input layers.
- Sits between block-RAM word readers and window/convolution processing in the input layer.
- Provides ready/valid handshakes on both sides, an exact occupancy count and a synchronous flush.

## Interface
Parameters:
- BYTE_W, 8, bits per byte lane
- IN_BYTES, 8, bytes per push word
- OUT_BYTES, 3, bytes per output window
- DEPTH_BYTES, 12, storage depth in bytes; legal only if DEPTH_BYTES >= IN_BYTES + OUT_BYTES - 1 (elaboration-time error otherwise)
- CNT_W, $clog2(DEPTH_BYTES+1), count width

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_data  in  IN_BYTES*BYTE_W  push word; byte lane 0 (LSBs) is oldest
- in_valid  in  1  push request
- in_ready  out  1  space for a full word
- out_data  out  OUT_BYTES*BYTE_W  window; lane 0 = oldest stored byte
- out_valid  out  1  at least OUT_BYTES bytes stored
- out_ready  in  1  pop request
- stride  in  $clog2(OUT_BYTES+1)  bytes retired on pop; 0 or > OUT_BYTES treated as OUT_BYTES
- flush  in  1  synchronous clear
- count  out  CNT_W  bytes currently stored

## Operation
- State: wr_ptr and rd_ptr (0..DEPTH_BYTES-1), count register (0..DEPTH_BYTES), byte storage. Storage is not reset.
- push = in_valid & in_ready: writes lanes 0..IN_BYTES-1 to wr_ptr+i mod DEPTH_BYTES; wr_ptr advances IN_BYTES mod DEPTH_BYTES.
- pop = out_valid & out_ready: rd_ptr advances eff_stride mod DEPTH_BYTES, where eff_stride is stride after the clamp rule.
- in_ready = (count <= DEPTH_BYTES - IN_BYTES). It depends on registered count only; there is no path from out_ready.
- out_valid = (count >= OUT_BYTES).
- out_data lane j = storage[rd_ptr + j mod DEPTH_BYTES], read combinationally. Contents are undefined while out_valid = 0 and must not be checked.
- count_next = count + (push ? IN_BYTES : 0) - (pop ? eff_stride : 0).
  - Simultaneous push and pop are always legal.
  - Each term is evaluated at CNT_W+1 bits; the result can never overflow given the handshake rules.
- Pointer wrap uses a compare-and-subtract modulo add (DEPTH_BYTES need not be a power of two).
- flush = 1: next edge sets wr_ptr = rd_ptr = count = 0. Flush overrides push and pop in the same cycle; data offered that cycle is dropped.
- reset = 1: immediately (asynchronously) sets pointers = 0 and count = 0, so in_ready = 1 and out_valid = 0. Reset mid-operation discards all contents.

## Timing
- Push-to-output latency is 1 cycle: a word pushed at edge N makes its bytes visible on out_data/out_valid after edge N.
- A pop at edge N presents the next window after edge N, so back-to-back pops every cycle are supported.
- Full throughput: one push and one pop per cycle when occupancy permits.
- The deadlock-free depth rule guarantees that whenever out_valid = 0, in_ready = 1.

## Structure
- Shared package gearbox_pkg:
  - BYTE_W default
  - clog2 helper
  - function mod_add(a, b, depth) for pointer wrap
  - stride clamp function
- One natural sub-module, byte_ring_store, holds:
  - DEPTH_BYTES x BYTE_W storage
  - IN_BYTES-lane rotated write port
  - OUT_BYTES-lane rotated read port
- Top level holds pointers, count and handshake logic.

## Test plan
Defaults throughout: IN=8, OUT=3, DEPTH=12.
1. Reset, then push 0x0706050403020100 → next cycle out_valid = 1, out_data = 0x020100, count = 8, in_ready = 0 (8 > 4).
2. From scenario 1, pop with stride = 3 twice → outputs 0x020100, then 0x050403; count = 2, out_valid = 0, in_ready = 1.
3. From scenario 1, pop with stride = 1 every cycle → 0x020100, 0x030201, 0x040302, …, 0x070605; out_valid drops at count = 2. Stride = 0 behaves as stride = 3.
4. Wrap continuity: push bytes 0x00–0x07, pop 3×stride 3 (count 2). Push 0x08–0x0F (crosses byte 11→0); stream pops of stride 1 → each window is consecutive values through 0x0D0C0B… with no discontinuity.
5. Simultaneous push and pop at count = 4 with stride 2 → count = 10 next cycle, window advances correctly.
6. Flush asserted together with push at count = 8 → count = 0, out_valid = 0, in_ready = 1, pushed word discarded. Separately, assert reset mid-stream between edges → outputs clear without waiting for clk.
